// File: rtl/lnvd_pkg.sv
// Shared constants and FSM encoding for the LNVD feedback path.
// The adder keeps bits [11:4]; this side pads them back out.
package lnvd_pkg;

  localparam int LNVD_CH    = 4;
  localparam int LNVD_IN_W  = 8;
  localparam int LNVD_OUT_W = 12;
  localparam int LNVD_PAD_W = LNVD_OUT_W - LNVD_IN_W;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } lnvd_state_e;

endpackage

// File: rtl/lnvd_process_delay_buffer_if.sv
// Sample-strobe bus between the feedback adder and the delay buffer.
// master drives samples and delay control; slave returns delayed samples.
interface lnvd_process_delay_buffer_if
  import lnvd_pkg::*;
#(
  parameter int PTR_W = 8
);

  logic                  sample_valid;
  logic [LNVD_IN_W-1:0]  data_in1;
  logic [LNVD_IN_W-1:0]  data_in2;
  logic [LNVD_IN_W-1:0]  data_in3;
  logic [LNVD_IN_W-1:0]  data_in4;
  logic [PTR_W-1:0]      delay_cfg;
  logic                  delay_load;
  logic [LNVD_OUT_W-1:0] data_out_buffer1;
  logic [LNVD_OUT_W-1:0] data_out_buffer2;
  logic [LNVD_OUT_W-1:0] data_out_buffer3;
  logic [LNVD_OUT_W-1:0] data_out_buffer4;
  logic                  out_valid;
  logic                  primed;

  modport master (
    output sample_valid,
    output data_in1,
    output data_in2,
    output data_in3,
    output data_in4,
    output delay_cfg,
    output delay_load,
    input  data_out_buffer1,
    input  data_out_buffer2,
    input  data_out_buffer3,
    input  data_out_buffer4,
    input  out_valid,
    input  primed
  );

  modport slave (
    input  sample_valid,
    input  data_in1,
    input  data_in2,
    input  data_in3,
    input  data_in4,
    input  delay_cfg,
    input  delay_load,
    output data_out_buffer1,
    output data_out_buffer2,
    output data_out_buffer3,
    output data_out_buffer4,
    output out_valid,
    output primed
  );

endinterface

// File: rtl/lnvd_sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Contents are deliberately not reset.
module lnvd_sample_ram #(
  parameter int DEPTH = 256,
  parameter int PTR_W = 8,
  parameter int W     = 48
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [W-1:0]     i_wdata,
  input  logic             i_re,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [W-1:0]     o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lnvd_process_delay_buffer.sv
// Circular delay store: captures four adder channels per sample strobe
// and replays them, re-expanded to 12 bits, a programmable number of samples later.
module lnvd_process_delay_buffer
  import lnvd_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 12,
  parameter int DEPTH     = 256,
  parameter int PTR_W     = 8,
  parameter int DELAY_RST = 64
) (
  input  logic clk,
  input  logic rst,
  lnvd_process_delay_buffer_if.slave bus
);

  localparam int W     = LNVD_CH * OUT_W;
  localparam int PAD_W = OUT_W - IN_W;

  lnvd_state_e      r_state;
  lnvd_state_e      w_state_nxt;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_fill_cnt;
  logic [PTR_W-1:0] w_fill_nxt;
  logic [PTR_W-1:0] r_delay;
  logic [PTR_W-1:0] w_delay_nxt;
  logic [PTR_W-1:0] w_dly_new;
  logic [PTR_W-1:0] w_dly;
  logic [PTR_W-1:0] w_rd_addr;
  logic             r_out_valid;
  logic             r_run_out;
  logic             w_run_out_nxt;
  logic [W-1:0]     w_wdata;
  logic [W-1:0]     w_rdata;

  // zero delay would read the slot being written; force it to 1
  assign w_dly_new = bus.delay_cfg | PTR_W'(~|bus.delay_cfg);
  assign w_dly     = bus.delay_load ? w_dly_new : r_delay;
  assign w_rd_addr = r_wr_ptr - w_dly;

  assign w_wdata = {
    bus.data_in1, {PAD_W{1'b0}},
    bus.data_in2, {PAD_W{1'b0}},
    bus.data_in3, {PAD_W{1'b0}},
    bus.data_in4, {PAD_W{1'b0}}
  };

  always_comb begin
    w_state_nxt   = r_state;
    w_fill_nxt    = r_fill_cnt;
    w_delay_nxt   = r_delay;
    w_run_out_nxt = r_run_out;
    if (bus.delay_load) begin
      w_delay_nxt = w_dly_new;
      w_fill_nxt  = PTR_W'(bus.sample_valid);
      w_state_nxt = ST_FILL;
    end else if (bus.sample_valid && r_state == ST_FILL) begin
      w_fill_nxt = r_fill_cnt + 1'b1;
    end
    if (bus.sample_valid && w_state_nxt == ST_FILL
        && w_fill_nxt >= w_delay_nxt) begin
      w_state_nxt = ST_RUN;
    end
    // output gating is decided by the state the strobe arrived in
    if (bus.sample_valid) begin
      w_run_out_nxt = (r_state == ST_RUN) && !bus.delay_load;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_fill_cnt  <= '0;
      r_delay     <= PTR_W'(DELAY_RST);
      r_out_valid <= 1'b0;
      r_run_out   <= 1'b0;
    end else begin
      r_fill_cnt  <= w_fill_nxt;
      r_delay     <= w_delay_nxt;
      r_out_valid <= bus.sample_valid;
      r_run_out   <= w_run_out_nxt;
      if (bus.sample_valid) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end
  end

  lnvd_sample_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     (W)
  ) u_ram (
    .clk     (clk),
    .i_we    (bus.sample_valid),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_re    (bus.sample_valid),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata)
  );

  // RAM output is unreset, so the reset-cleared gate masks it
  assign bus.data_out_buffer1 = r_run_out ? w_rdata[4*OUT_W-1 -: OUT_W] : '0;
  assign bus.data_out_buffer2 = r_run_out ? w_rdata[3*OUT_W-1 -: OUT_W] : '0;
  assign bus.data_out_buffer3 = r_run_out ? w_rdata[2*OUT_W-1 -: OUT_W] : '0;
  assign bus.data_out_buffer4 = r_run_out ? w_rdata[1*OUT_W-1 -: OUT_W] : '0;
  assign bus.out_valid        = r_out_valid;
  assign bus.primed           = (r_state == ST_RUN);

endmodule

// File: tb/tb_lnvd_process_delay_buffer.sv
// Bench for lnvd_process_delay_buffer: vector table, directed corners,
// and random traffic checked against a sample-history model.
module tb_lnvd_process_delay_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lnvd_process_delay_buffer_if #(.PTR_W(8)) bus();

  lnvd_process_delay_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int ov_cnt = 0;

  always @(negedge clk) if (bus.out_valid) ov_cnt++;

  // model: every sample ever written since reset, plus delay/fill state
  logic [31:0] m_hist[$];
  int          m_delay;
  int          m_fill;
  bit          m_primed;

  typedef struct {
    bit          ld;
    logic [7:0]  cfg;
    logic [31:0] din;
    logic [31:0] exp;
    bit          pr;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic chk_outs(input string nm, input logic [31:0] e);
    chk({nm, ".o1"}, 32'(bus.data_out_buffer1), {20'd0, e[31:24], 4'h0});
    chk({nm, ".o2"}, 32'(bus.data_out_buffer2), {20'd0, e[23:16], 4'h0});
    chk({nm, ".o3"}, 32'(bus.data_out_buffer3), {20'd0, e[15:8], 4'h0});
    chk({nm, ".o4"}, 32'(bus.data_out_buffer4), {20'd0, e[7:0], 4'h0});
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_delay  = 64;
    m_fill   = 0;
    m_primed = 0;
  endtask

  task automatic strobe(input logic [31:0] d, input bit ld,
                        input logic [7:0] cfg, input string nm);
    logic [31:0] e;
    int idx;
    @(negedge clk);
    bus.data_in1     = d[31:24];
    bus.data_in2     = d[23:16];
    bus.data_in3     = d[15:8];
    bus.data_in4     = d[7:0];
    bus.delay_load   = ld;
    bus.delay_cfg    = cfg;
    bus.sample_valid = 1'b1;
    if (ld) m_delay = (cfg == 0) ? 1 : int'(cfg);
    e = '0;
    idx = m_hist.size() - m_delay;
    if (m_primed && !ld && idx >= 0) e = m_hist[idx];
    m_hist.push_back(d);
    if (ld) m_fill = 1;
    else if (!m_primed) m_fill++;
    if (ld || !m_primed) m_primed = (m_fill >= m_delay);
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    bus.delay_load   = 1'b0;
    chk({nm, ".ov"}, 32'(bus.out_valid), 32'd1);
    chk_outs(nm, e);
    chk({nm, ".pr"}, 32'(bus.primed), 32'(m_primed));
  endtask

  task automatic load_only(input logic [7:0] cfg, input string nm);
    @(negedge clk);
    bus.delay_load = 1'b1;
    bus.delay_cfg  = cfg;
    m_delay  = (cfg == 0) ? 1 : int'(cfg);
    m_fill   = 0;
    m_primed = 0;
    @(posedge clk);
    #1;
    bus.delay_load = 1'b0;
    chk({nm, ".pr"}, 32'(bus.primed), 32'd0);
  endtask

  task automatic idle(input string nm);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk({nm, ".ov"}, 32'(bus.out_valid), 32'd0);
  endtask

  logic [31:0] wr[300];

  initial begin
    bus.sample_valid = 1'b0;
    bus.delay_load   = 1'b0;
    bus.delay_cfg    = '0;
    bus.data_in1     = '0;
    bus.data_in2     = '0;
    bus.data_in3     = '0;
    bus.data_in4     = '0;
    model_reset();

    tbl[0] = '{1'b1, 8'd3, 32'h00A0_0000, 32'h0000_0000, 1'b0};
    tbl[1] = '{1'b0, 8'd0, 32'h00A1_0000, 32'h0000_0000, 1'b0};
    tbl[2] = '{1'b0, 8'd0, 32'h00A2_0000, 32'h0000_0000, 1'b1};
    tbl[3] = '{1'b0, 8'd0, 32'h00A3_0000, 32'h00A0_0000, 1'b1};
    tbl[4] = '{1'b1, 8'd0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    tbl[5] = '{1'b0, 8'd0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
    tbl[6] = '{1'b0, 8'd0, 32'h5555_5555, 32'h0000_0000, 1'b1};
    tbl[7] = '{1'b0, 8'd0, 32'h1234_5678, 32'h5555_5555, 1'b1};

    #3;
    chk("rst.ov", 32'(bus.out_valid), 32'd0);
    chk("rst.pr", 32'(bus.primed), 32'd0);
    chk_outs("rst", 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ov_cnt = 0;

    // default delay 64 fill
    for (int i = 1; i <= 64; i++) begin
      strobe({8'(i), 24'h0}, 1'b0, 8'd0, $sformatf("fill%0d", i));
      if (i == 63) chk("fill.pr63", 32'(bus.primed), 32'd0);
      if (i == 64) chk("fill.pr64", 32'(bus.primed), 32'd1);
      if (i % 16 == 0) idle("fill.idle");
    end
    chk("fill.ovcnt", 32'(ov_cnt), 32'd64);
    strobe(32'h4100_0000, 1'b0, 8'd0, "s65");
    chk("s65.o1", 32'(bus.data_out_buffer1), 32'h010);

    for (int i = 0; i < 8; i++) begin
      strobe(tbl[i].din, tbl[i].ld, tbl[i].cfg, $sformatf("tbl%0d", i));
      chk($sformatf("tv%0d.o1", i), 32'(bus.data_out_buffer1),
          {20'd0, tbl[i].exp[31:24], 4'h0});
      chk($sformatf("tv%0d.o2", i), 32'(bus.data_out_buffer2),
          {20'd0, tbl[i].exp[23:16], 4'h0});
      chk($sformatf("tv%0d.o4", i), 32'(bus.data_out_buffer4),
          {20'd0, tbl[i].exp[7:0], 4'h0});
      chk($sformatf("tv%0d.pr", i), 32'(bus.primed), 32'(tbl[i].pr));
    end

    // delay 255, pointer wraps
    load_only(8'd255, "ld255");
    for (int k = 0; k < 300; k++) begin
      wr[k] = $urandom;
      strobe(wr[k], 1'b0, 8'd0, $sformatf("wrap%0d", k));
      if (k == 254) chk("wrap.pr254", 32'(bus.primed), 32'd1);
      if (k >= 255) chk_outs($sformatf("wrapx%0d", k), wr[k-255]);
    end

    // coincident load during RUN
    strobe(32'hDEAD_BEEF, 1'b1, 8'd5, "co");
    chk("co.pr", 32'(bus.primed), 32'd0);
    chk_outs("co.z", 32'd0);
    for (int i = 0; i < 4; i++) begin
      strobe($urandom, 1'b0, 8'd0, $sformatf("co%0d", i));
      chk($sformatf("co.pr%0d", i), 32'(bus.primed), 32'(i == 3));
    end
    strobe(32'h0102_0304, 1'b0, 8'd0, "co.run");
    chk_outs("co.first", 32'hDEAD_BEEF);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) load_only(8'($urandom_range(0, 20)), "rnd.ld");
      else if (r < 9)
        strobe($urandom, 1'b1, 8'($urandom_range(0, 20)), "rnd.co");
      else if (r < 20) idle("rnd.idle");
      else strobe($urandom, 1'b0, 8'd0, "rnd");
    end

    // async reset mid-stream during RUN
    load_only(8'd2, "pre");
    repeat (4) strobe($urandom, 1'b0, 8'd0, "pre.s");
    chk("pre.ov", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.ov", 32'(bus.out_valid), 32'd0);
    chk("arst.pr", 32'(bus.primed), 32'd0);
    chk_outs("arst", 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 64; i++) begin
      strobe($urandom, 1'b0, 8'd0, $sformatf("refill%0d", i));
      if (i == 63) chk("refill.pr63", 32'(bus.primed), 32'd0);
    end
    chk("refill.pr64", 32'(bus.primed), 32'd1);
    repeat (5) strobe($urandom, 1'b0, 8'd0, "post");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
